// File: rtl/mmio_port_responder_pkg.sv
// Shared register map and bit positions for the MMIO port responder.
package mmio_port_responder_pkg;

   localparam int unsigned ADDR_W = 8;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_RXDATA = 2'd1;
   localparam logic [1:0] OFF_STATUS = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   localparam int unsigned ST_TX_FULL     = 0;
   localparam int unsigned ST_TX_EMPTY    = 1;
   localparam int unsigned ST_RX_AVAIL    = 2;
   localparam int unsigned ST_RX_OVERRUN  = 3;
   localparam int unsigned ST_TX_OVERFLOW = 4;

   localparam int unsigned CTRL_CLR = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_fire;
   logic             pop_fire;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pop_fire  = pop && !empty;
      push_fire = push && (!full || pop_fire);
      if (push_fire) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_fire) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_fire) - CW'(pop_fire);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mmio_port_responder.sv
// 4-register MMIO window on the shared CPU bus: buffered TX stream out,
// single-byte RX holding register in, plus status/control.
module mmio_port_responder
   import mmio_port_responder_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR = 8'hF0,
   parameter int unsigned TX_DEPTH  = 4,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ADDRESS,
   inout  wire  [DATA_W-1:0] DATA_BUS,
   input  logic              M_read,
   input  logic              M_write,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid
);

   localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rx_avail_q, rx_avail_d;
   logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
   logic              rx_overrun_q, rx_overrun_d;
   logic              tx_overflow_q, tx_overflow_d;

   logic              hit_c;
   logic [1:0]        offset_c;
   logic              addr_chg_c;
   logic              new_wr_c;
   logic              new_rd_c;
   logic              drive_c;
   logic [DATA_W-1:0] rd_data_c;
   logic [DATA_W-1:0] status_c;
   logic              tx_push_c;
   logic              tx_pop_c;
   logic              rx_pop_c;
   logic              clr_c;
   logic              overflow_evt_c;
   logic              overrun_evt_c;

   logic              tx_full;
   logic              tx_empty;
   logic [CW-1:0]     tx_count;

   // Decode and once-per-access qualification of the CPU strobes.
   always_comb begin
      hit_c      = (ADDRESS[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
      offset_c   = ADDRESS[1:0];
      addr_chg_c = (ADDRESS != addr_q);
      new_wr_c   = M_write && (!wr_q || addr_chg_c);
      new_rd_c   = M_read && !M_write && (!rd_q || addr_chg_c);
      drive_c    = M_read && !M_write && hit_c && !rst;
      tx_push_c  = new_wr_c && hit_c && (offset_c == OFF_TXDATA);
      clr_c      = new_wr_c && hit_c && (offset_c == OFF_CTRL) && DATA_BUS[CTRL_CLR];
      rx_pop_c   = new_rd_c && hit_c && (offset_c == OFF_RXDATA) && rx_avail_q;
      tx_pop_c   = tx_valid && tx_ready;
   end

   always_comb begin
      status_c                 = '0;
      status_c[ST_TX_FULL]     = tx_full;
      status_c[ST_TX_EMPTY]    = tx_empty;
      status_c[ST_RX_AVAIL]    = rx_avail_q;
      status_c[ST_RX_OVERRUN]  = rx_overrun_q;
      status_c[ST_TX_OVERFLOW] = tx_overflow_q;
      rd_data_c                = '0;
      case (offset_c)
         OFF_RXDATA: rd_data_c = rx_avail_q ? rx_hold_q : '0;
         OFF_STATUS: rd_data_c = status_c;
         default:    rd_data_c = '0;
      endcase
   end

   assign DATA_BUS = drive_c ? rd_data_c : {DATA_W{1'bz}};

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push_c),
      .pop   (tx_ready),
      .wdata (DATA_BUS),
      .rdata (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   assign tx_valid = (tx_count != '0);

   // RX holding register and sticky flags; a new event outranks a clear.
   always_comb begin
      rd_d           = M_read;
      wr_d           = M_write;
      addr_d         = ADDRESS;
      rx_avail_d     = rx_avail_q;
      rx_hold_d      = rx_hold_q;
      rx_overrun_d   = rx_overrun_q;
      tx_overflow_d  = tx_overflow_q;
      overflow_evt_c = tx_push_c && tx_full && !tx_pop_c;
      overrun_evt_c  = 1'b0;

      if (rx_valid) begin
         if (!rx_avail_q || rx_pop_c) begin
            rx_hold_d  = rx_data;
            rx_avail_d = 1'b1;
         end else begin
            overrun_evt_c = 1'b1;
         end
      end else if (rx_pop_c) begin
         rx_avail_d = 1'b0;
      end

      if (clr_c) begin
         rx_overrun_d  = 1'b0;
         tx_overflow_d = 1'b0;
      end
      if (overrun_evt_c) begin
         rx_overrun_d = 1'b1;
      end
      if (overflow_evt_c) begin
         tx_overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         rx_avail_q    <= 1'b0;
         rx_hold_q     <= '0;
         rx_overrun_q  <= 1'b0;
         tx_overflow_q <= 1'b0;
      end else begin
         rd_q          <= rd_d;
         wr_q          <= wr_d;
         addr_q        <= addr_d;
         rx_avail_q    <= rx_avail_d;
         rx_hold_q     <= rx_hold_d;
         rx_overrun_q  <= rx_overrun_d;
         tx_overflow_q <= tx_overflow_d;
      end
   end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's shared 8-bit address/data bus, sitting alongside the data memory.
- It answers the processor's M_read/M_write accesses in a 4-byte window.
- CPU writes are buffered into a TX FIFO and drained through a valid/ready stream to an external consumer.
- Bytes arriving from an external producer are held for the CPU to read.

Parameters:
- BASE_ADDR, 8'hF0, first address of the 4-byte register window; the low 2 bits must be 0.
- TX_DEPTH, 4, TX FIFO entries; must be a power of 2 and at least 2.
- DATA_W, 8, bus and data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ADDRESS  in  8  processor address bus.
- DATA_BUS  inout  DATA_W  shared data bus; the block drives it only during a read hit, otherwise high-Z.
- M_read  in  1  processor read strobe; level, may be held for several cycles.
- M_write  in  1  processor write strobe; level, may be held for several cycles.
- tx_data  out  DATA_W  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  consumer accepts tx_data on a rising edge when tx_valid && tx_ready.
- rx_data  in  DATA_W  inbound byte.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0 TXDATA: W pushes a byte; R returns 0.
  - 1 RXDATA: R returns the holding register and pops it.
  - 2 STATUS: R only; bit0 tx_full, bit1 tx_empty, bit2 rx_avail, bit3 rx_overrun (sticky), bit4 tx_overflow (sticky), bits7:5 read 0.
  - 3 CTRL: W with bit0=1 clears both sticky flags; R returns 0.
- Hit: ADDRESS[7:2] == BASE_ADDR[7:2]. Anything outside the window is ignored and the bus is never driven.
- Read data path: combinational. DATA_BUS = register value while M_read && hit && !M_write, else 'z. Zero-cycle latency from ADDRESS/M_read.
- Both strobes high: treated as a write only; no drive, no read side-effect.
- Side effects (push, pop, clear) fire once per access, on the first rising edge of the access.
  - An access is new when the strobe was low on the previous edge, or ADDRESS changed while the strobe was held.
  - Registered copies of the strobes and address implement this; they reset to 0.
  - Holding M_write for N cycles pushes exactly one byte.
- TX push when not full: byte is written at the tail. tx_valid and tx_data update on the next edge; there is no same-cycle bypass.
- TX push when full, with no pop on the same edge: byte is dropped and tx_overflow is set.
- Push while full and a pop on the same edge: both happen; count stays TX_DEPTH and no overflow is flagged.
- TX pop when tx_valid && tx_ready; the head advances.
- Pointers wrap modulo TX_DEPTH. Count width is clog2(TX_DEPTH)+1.
- RX holding register:
  - rx_valid with the register empty: capture rx_data and set rx_avail.
  - rx_valid with it full and no CPU pop on the same edge: new byte discarded, existing byte kept, rx_overrun set.
  - CPU pop and rx_valid on the same edge: the new byte is captured, rx_avail stays 1, no overrun.
  - CPU pop with no rx_valid: rx_avail cleared. RXDATA read when empty returns 0 and has no effect.
- CTRL clear and a new overflow/overrun event on the same edge: the event wins and the flag stays 1.
- Reset (at any time, including mid-access or with the FIFO non-empty):
  - FIFO emptied; tx_valid=0, tx_data=0.
  - rx_avail=0; holding register = 0.
  - Sticky flags = 0; edge-detect registers = 0.
  - DATA_BUS high-Z.
  - Strobes held through reset release count as new accesses on the first edge after rst falls.

Decomposition:
- Shared package holds:
  - Register offsets: OFF_TXDATA=0, OFF_RXDATA=1, OFF_STATUS=2, OFF_CTRL=3.
  - STATUS bit indices.
  - CTRL_CLR bit index.
- One sub-module: sync_fifo (parameterised width and depth; push, pop, full, empty, count, head data), instantiated for TX.
- Bus decode, edge detect, RX holding register and status logic live in mmio_port_responder.

Test Plan:
- Reset, then read F2 -> DATA_BUS=8'h02 (tx_empty only). Read 0x10 -> DATA_BUS is Z.
- tx_ready=0. Write 8'hA1 to F0 with M_write held 3 cycles -> exactly one push. tx_valid=1 next edge, tx_data=A1, STATUS=8'h00.
- tx_ready=0. Write A1,A2,A3,A4,A5 -> STATUS=8'h11 (full plus overflow). Raise tx_ready -> A1..A4 drained in order, one per cycle, then tx_valid=0. Write CTRL=01 -> STATUS=8'h02.
- rx_valid with 8'h5C -> STATUS bit2=1. A second rx_valid with 8'h77 before any read -> overrun set. Read F1 -> 5C, then STATUS=8'h0A.
- Read F1 holding 8'h11 while rx_valid brings 8'h22 on the same edge -> bus shows 11, rx_avail stays 1, no overrun. Next read returns 22.
- Four bytes queued; assert rst for 1 cycle during a held M_write -> tx_valid=0, STATUS=8'h02 after release, and exactly one push once rst falls.
